// File: rtl/noc_pkg.sv
// Shared constants and types for the mesh switch output-port logic.
package noc_pkg;
   localparam int DATA_W    = 42;
   localparam int NUM_PORTS = 5;

   localparam int PORT_N  = 0;
   localparam int PORT_S  = 1;
   localparam int PORT_E  = 2;
   localparam int PORT_W  = 3;
   localparam int PORT_PE = 4;

   typedef logic [DATA_W-1:0] flit_t;
endpackage

// File: rtl/noc_rr_arbiter.sv
// Combinational rotate-priority selector: first requester at or after rr_ptr wins.
module noc_rr_arbiter
   import noc_pkg::*;
#(
   parameter int NUM_IN = NUM_PORTS
) (
   input  logic [NUM_IN-1:0]         i_req,
   input  logic [$clog2(NUM_IN)-1:0] i_rr_ptr,
   output logic                      o_any,
   output logic [$clog2(NUM_IN)-1:0] o_winner,
   output logic [NUM_IN-1:0]         o_grant
);
   localparam int IDX_W = $clog2(NUM_IN);

   logic [IDX_W:0] idx;

   // Scan from the farthest offset down so the nearest requester is written last.
   always_comb begin
      o_any    = 1'b0;
      o_winner = '0;
      o_grant  = '0;
      idx      = '0;
      for (int i = NUM_IN - 1; i >= 0; i--) begin
         idx = {1'b0, i_rr_ptr} + (IDX_W + 1)'(i);
         if (idx >= (IDX_W + 1)'(NUM_IN)) begin
            idx = idx - (IDX_W + 1)'(NUM_IN);
         end
         if (i_req[idx[IDX_W-1:0]]) begin
            o_any    = 1'b1;
            o_winner = idx[IDX_W-1:0];
         end
      end
      if (o_any) begin
         o_grant[o_winner] = 1'b1;
      end
   end
endmodule

// File: rtl/noc_out_port_arbiter.sv
// Output-port arbiter: round-robin accept of single-flit packets into a
// 2-entry buffer that feeds the downstream valid/ready link.
module noc_out_port_arbiter #(
   parameter int NUM_IN = noc_pkg::NUM_PORTS,
   parameter int DATA_W = noc_pkg::DATA_W,
   parameter int CNT_W  = 16
) (
   input  logic                     i_clk,
   input  logic                     i_rst_n,
   input  logic [NUM_IN-1:0]        i_req_valid,
   output logic [NUM_IN-1:0]        o_req_ready,
   input  logic [NUM_IN*DATA_W-1:0] i_req_data,
   output logic                     o_valid,
   input  logic                     i_ready,
   output logic [DATA_W-1:0]        o_data,
   output logic [NUM_IN-1:0]        o_last_grant,
   output logic [CNT_W-1:0]         o_flit_cnt
);
   import noc_pkg::*;

   localparam int PTR_W = $clog2(NUM_IN);

   logic [DATA_W-1:0] mem_q [2];
   logic [DATA_W-1:0] mem_d [2];
   logic              head_q, head_d;
   logic [1:0]        count_q, count_d;
   logic [PTR_W-1:0]  rr_ptr_q, rr_ptr_d;
   logic [NUM_IN-1:0] last_grant_q, last_grant_d;
   logic [CNT_W-1:0]  flit_cnt_q, flit_cnt_d;

   logic              any_req;
   logic [PTR_W-1:0]  winner;
   logic [NUM_IN-1:0] grant;
   logic              space, push, pop, tail;

   noc_rr_arbiter #(.NUM_IN(NUM_IN)) u_rr (
      .i_req    (i_req_valid),
      .i_rr_ptr (rr_ptr_q),
      .o_any    (any_req),
      .o_winner (winner),
      .o_grant  (grant)
   );

   // Space depends only on the registered count, so a full buffer never
   // accepts in the same cycle it drains.
   assign space = (count_q != 2'd2);
   assign push  = any_req & space;
   assign pop   = (count_q != 2'd0) & i_ready;
   assign tail  = head_q ^ (count_q == 2'd1);

   assign o_req_ready  = grant & {NUM_IN{space}};
   assign o_valid      = (count_q != 2'd0);
   assign o_data       = mem_q[head_q];
   assign o_last_grant = last_grant_q;
   assign o_flit_cnt   = flit_cnt_q;

   always_comb begin
      mem_d        = mem_q;
      head_d       = head_q;
      count_d      = count_q;
      rr_ptr_d     = rr_ptr_q;
      last_grant_d = last_grant_q;
      flit_cnt_d   = flit_cnt_q;
      if (push) begin
         mem_d[tail]  = i_req_data[int'(winner)*DATA_W +: DATA_W];
         rr_ptr_d     = (winner == PTR_W'(NUM_IN - 1)) ? '0 : winner + 1'b1;
         last_grant_d = grant;
      end
      if (pop) begin
         head_d     = ~head_q;
         flit_cnt_d = flit_cnt_q + CNT_W'(1);
      end
      case ({push, pop})
         2'b10:   count_d = count_q + 2'd1;
         2'b01:   count_d = count_q - 2'd1;
         default: count_d = count_q;
      endcase
   end

   always_ff @(posedge i_clk) begin
      if (!i_rst_n) begin
         head_q       <= 1'b0;
         count_q      <= 2'd0;
         rr_ptr_q     <= '0;
         last_grant_q <= '0;
         flit_cnt_q   <= '0;
      end else begin
         head_q       <= head_d;
         count_q      <= count_d;
         rr_ptr_q     <= rr_ptr_d;
         last_grant_q <= last_grant_d;
         flit_cnt_q   <= flit_cnt_d;
      end
   end

   // Storage needs no reset: entries are only read while the count covers them.
   always_ff @(posedge i_clk) begin
      mem_q <= mem_d;
   end
endmodule

// File: tb/tb_noc_out_port_arbiter.sv
// Directed bench: stimulus queues expected flits, a negedge monitor checks them.
module tb_noc_out_port_arbiter;
   import noc_pkg::*;

   localparam int N  = NUM_PORTS;
   localparam int CW = 16;

   logic              clk = 1'b0;
   logic              rst_n;
   logic [N-1:0]      req_valid;
   logic [N-1:0]      req_ready;
   logic [N*DATA_W-1:0] req_data;
   logic              o_valid;
   logic              i_ready;
   logic [DATA_W-1:0] o_data;
   logic [N-1:0]      last_grant;
   logic [CW-1:0]     flit_cnt;

   int    n_tests = 0;
   int    n_fail  = 0;
   int    exp_cnt = 0;
   int    rem [N];
   int    seqn [N];
   flit_t exp_q [$];

   always #5 clk = ~clk;

   noc_out_port_arbiter #(.NUM_IN(N), .DATA_W(DATA_W), .CNT_W(CW)) dut (
      .i_clk        (clk),
      .i_rst_n      (rst_n),
      .i_req_valid  (req_valid),
      .o_req_ready  (req_ready),
      .i_req_data   (req_data),
      .o_valid      (o_valid),
      .i_ready      (i_ready),
      .o_data       (o_data),
      .o_last_grant (last_grant),
      .o_flit_cnt   (flit_cnt)
   );

   function automatic flit_t mk_flit(int k, int s);
      return {8'(k), 8'(s), 26'h2A5A5A5};
   endfunction

   task automatic check(string name, logic [63:0] act, logic [63:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end else begin
         $display("[TB] ok %s = %0h", name, act);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic set_req(int k, int count);
      rem[k] = count;
      req_data[k*DATA_W +: DATA_W] = mk_flit(k, seqn[k]);
      req_valid[k] = (count > 0);
   endtask

   // Expect input k to win this cycle, queue its flit, then advance the requester.
   task automatic accept(int k, string name);
      logic [N-1:0] oh;
      oh = '0;
      oh[k] = 1'b1;
      #1;
      check({name, " ready"}, 64'(req_ready), 64'(oh));
      exp_q.push_back(req_data[k*DATA_W +: DATA_W]);
      tick();
      check({name, " last_grant"}, 64'(last_grant), 64'(oh));
      rem[k]--;
      seqn[k]++;
      if (rem[k] == 0) begin
         req_valid[k] = 1'b0;
      end else begin
         req_data[k*DATA_W +: DATA_W] = mk_flit(k, seqn[k]);
      end
   endtask

   always @(negedge clk) begin
      if (!rst_n) begin
         exp_cnt = 0;
      end else begin
         check("flit_cnt", 64'(flit_cnt), 64'(CW'(exp_cnt)));
         if (o_valid && i_ready) begin
            if (exp_q.size() == 0) begin
               n_tests++;
               n_fail++;
               $display("FAIL out_data: got %0h expected no flit", o_data);
            end else begin
               check("out_data", 64'(o_data), 64'(exp_q.pop_front()));
            end
            exp_cnt++;
         end
      end
   end

   initial begin
      #100000;
      $display("FAIL watchdog: got timeout expected $finish");
      $fatal(1, "watchdog");
   end

   initial begin
      int    order [7];
      flit_t f_pe, f1, f3a;

      rst_n     = 1'b0;
      req_valid = '0;
      req_data  = '0;
      i_ready   = 1'b0;
      for (int k = 0; k < N; k++) seqn[k] = 0;

      // Reset held with every input requesting.
      for (int k = 0; k < N; k++) set_req(k, (k < 2) ? 2 : 1);
      repeat (3) tick();
      check("rst o_valid", 64'(o_valid), 64'(0));
      check("rst last_grant", 64'(last_grant), 64'(0));
      check("rst flit_cnt", 64'(flit_cnt), 64'(0));
      rst_n   = 1'b1;
      i_ready = 1'b1;

      // Fairness: 0,1,2,3,4,0,1 at one flit per cycle.
      order = '{0, 1, 2, 3, 4, 0, 1};
      for (int i = 0; i < 7; i++) accept(order[i], $sformatf("fair%0d", i));
      #1;
      check("idle ready", 64'(req_ready), 64'(0));
      tick();
      check("fair drained", 64'(o_valid), 64'(0));
      check("fair cnt", 64'(flit_cnt), 64'(7));

      // Single PE flit, one-cycle latency.
      set_req(PORT_PE, 1);
      req_data[PORT_PE*DATA_W +: DATA_W] = 42'h3FF_0000_0001;
      f_pe = 42'h3FF_0000_0001;
      accept(PORT_PE, "pe");
      check("pe o_valid", 64'(o_valid), 64'(1));
      check("pe o_data", 64'(o_data), 64'(f_pe));
      tick();
      check("pe cnt", 64'(flit_cnt), 64'(8));

      // Backpressure: fill the buffer, confirm stall, then drain in order.
      i_ready = 1'b0;
      set_req(PORT_S, 1);
      set_req(PORT_W, 2);
      f1  = req_data[PORT_S*DATA_W +: DATA_W];
      f3a = req_data[PORT_W*DATA_W +: DATA_W];
      accept(PORT_S, "bp1");
      accept(PORT_W, "bp3");
      #1;
      check("full ready", 64'(req_ready), 64'(0));
      tick();
      #1;
      check("full ready2", 64'(req_ready), 64'(0));
      check("full o_valid", 64'(o_valid), 64'(1));
      check("full o_data held", 64'(o_data), 64'(f1));
      i_ready = 1'b1;
      #1;
      check("full ready w/ i_ready", 64'(req_ready), 64'(0));
      tick();
      check("bp head after pop", 64'(o_data), 64'(f3a));
      accept(PORT_W, "bp3b");
      tick();
      check("bp drained", 64'(o_valid), 64'(0));

      // Simultaneous push and pop holds count at one.
      set_req(PORT_E, 11);
      for (int i = 0; i < 11; i++) begin
         accept(PORT_E, $sformatf("pp%0d", i));
         check($sformatf("pp%0d o_valid", i), 64'(o_valid), 64'(1));
      end
      tick();
      check("pp drained", 64'(o_valid), 64'(0));

      // Reset with a full buffer discards contents and restarts priority at 0.
      i_ready = 1'b0;
      set_req(PORT_E, 2);
      set_req(PORT_PE, 2);
      accept(PORT_PE, "rm4");
      accept(PORT_E, "rm2");
      exp_q.delete();
      rst_n = 1'b0;
      tick();
      rst_n = 1'b1;
      #1;
      check("mid rst o_valid", 64'(o_valid), 64'(0));
      check("mid rst flit_cnt", 64'(flit_cnt), 64'(0));
      check("mid rst last_grant", 64'(last_grant), 64'(0));
      i_ready = 1'b1;
      accept(PORT_E, "post_rst2");
      accept(PORT_PE, "post_rst4");
      tick();
      tick();
      check("final o_valid", 64'(o_valid), 64'(0));
      check("scoreboard empty", 64'(exp_q.size()), 64'(0));

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end
endmodule

// File: doc/noc_out_port_arbiter.md
Name: noc_out_port_arbiter

Overview:
- Per-output-port arbiter for a mesh switch. It shares one switch output (N, S, E, W or PE direction) between the five switch input ports.
- Uses round-robin selection of single-flit packets under valid/ready handshakes.
- A 2-entry output buffer decouples the downstream ready from arbitration.
- Five instances per switch, one per output direction. Each instance drives the inter-switch o_*_valid/o_*_data wires and consumes i_*_ready.

Parameters:
- NUM_IN, 5, number of requesting input ports (index order N=0, S=1, E=2, W=3, PE=4).
- DATA_W, 42, flit width in bits (41:0).
- CNT_W, 16, width of the forwarded-flit statistics counter.

Ports:
- i_clk  input  1  clock, all logic rising-edge.
- i_rst_n  input  1  synchronous reset, active-low.
- i_req_valid  input  NUM_IN  per-input flit valid.
- o_req_ready  output  NUM_IN  per-input ready, at most one bit high.
- i_req_data  input  NUM_IN*DATA_W  flattened flits; input k occupies bits [k*DATA_W +: DATA_W].
- o_valid  output  1  output flit valid (registered).
- i_ready  input  1  downstream ready.
- o_data  output  DATA_W  output flit (registered buffer head).
- o_last_grant  output  NUM_IN  one-hot index of the last accepted input (registered).
- o_flit_cnt  output  CNT_W  number of flits forwarded downstream, wraps.

Behaviour:
- Reset (i_rst_n=0 at a clock edge):
  - buffer count=0, rr_ptr=0, o_last_grant=0, o_flit_cnt=0.
  - o_valid=0, o_req_ready=0 while count forced 0 is not applicable; o_req_ready follows normal rule after reset is released.
  - Buffered flits are discarded.
- space = (count < 2), computed from the registered count only. Pop-and-push in the same cycle is not allowed when count==2.
- Winner selection (combinational): the first k with i_req_valid[k]=1, scanning rr_ptr, rr_ptr+1, ... mod NUM_IN.
- o_req_ready[winner]=1 iff space and at least one valid; all other bits 0.
- No valid requests -> o_req_ready=0.
- Push (accept) = i_req_valid[winner] & o_req_ready[winner]. On push:
  - the flit of the winner is written to the buffer tail;
  - rr_ptr <= (winner+1) mod NUM_IN;
  - o_last_grant <= onehot(winner).
- rr_ptr and o_last_grant are unchanged on cycles without a push.
- Pop = o_valid & i_ready.
  - o_valid = (count != 0); o_data = buffer head.
  - On pop the head advances, and o_flit_cnt increments with modulo 2^CNT_W wrap.
- Count update: push only -> +1; pop only -> -1; push and pop together (count==1 only) -> count stays 1, new flit becomes head next cycle.
- Latency: a flit accepted at edge t appears on o_valid/o_data after edge t (next cycle) when the buffer was empty.
- Sustained throughput: 1 flit/cycle while i_ready=1.
- Ordering: flits leave in acceptance order. Nothing is dropped except on reset.
- Requester rule: i_req_valid/i_req_data are held stable until accepted. A valid may not be withdrawn.
- Downstream contract: o_valid/o_data are held stable while o_valid & !i_ready.
- Full (count==2): all o_req_ready=0 regardless of i_ready that cycle. Accepting resumes the cycle after a pop.
- Empty: o_valid=0 and o_data holds its last value (don't-care).
- Reset asserted mid-transfer: applies on the next edge; in-flight handshakes on that edge are ignored.

Decomposition:
- Package noc_pkg:
  - DATA_W=42, NUM_PORTS=5;
  - port index constants PORT_N=0, PORT_S=1, PORT_E=2, PORT_W=3, PORT_PE=4;
  - flit_t typedef (DATA_W bits).
- Sub-module noc_rr_arbiter: combinational rotate-priority select from (req, rr_ptr), outputting winner index and one-hot grant.
- The 2-entry buffer, pointer register and counters stay in the top of this block.

Test Plan:
- Reset: hold i_rst_n=0 for 3 cycles with all i_req_valid=1 -> o_valid=0, o_last_grant=0, o_flit_cnt=0. First cycle after release: o_req_ready=5'b00001.
- Single flit: PE valid with data 42'h3FF_0000_0001, i_ready=1.
  - o_req_ready[4]=1 in the accept cycle.
  - Next cycle: o_valid=1, o_data=42'h3FF_0000_0001, o_last_grant=5'b10000.
  - o_flit_cnt=1 after the pop.
- Fairness: all five inputs continuously valid, i_ready=1 -> accepted order 0,1,2,3,4,0,1; one flit per cycle; o_flit_cnt increments every cycle.
- Backpressure: i_ready=0, inputs 1 and 3 valid.
  - Input 1 is accepted, then input 3; afterwards o_req_ready=0.
  - Raise i_ready -> o_data shows input 1's flit, then input 3's flit, with no loss or duplication.
- Simultaneous push/pop: with count=1 and i_ready=1, input 2 valid each cycle -> count stays 1 and o_valid stays high for 10 consecutive cycles.
- Reset mid-operation: with count=2, pulse i_rst_n=0 for 1 cycle -> next cycle o_valid=0 and o_flit_cnt=0. Subsequent grant starts from input 0.
